// File: rtl/exec_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// One radix-2 step per cycle; stalls upstream until the result is ready.
module exec_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [4:0]            rd_in,
    input  logic                  flush,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [4:0]            rd_out
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic [4:0]      r_rd;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_spec;
    logic [W-1:0]    r_spec_val;
    logic [W-1:0]    r_b;
    logic [2*W-1:0]  r_a2;
    logic [2*W-1:0]  r_acc;

    logic            w_a_sgn;
    logic            w_b_sgn;
    logic            w_sa;
    logic            w_sb;
    logic [W-1:0]    w_abs_a;
    logic [W-1:0]    w_abs_b;
    logic [W-1:0]    w_min;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_spec;
    logic [W-1:0]    w_spec_val;
    logic            w_accept;
    logic            w_last;
    logic [2*W-1:0]  w_acc_nxt;
    logic [W:0]      w_rem_sh;
    logic [W:0]      w_rem_sub;
    logic            w_ge;
    logic [W-1:0]    w_rem_nxt;
    logic [W-1:0]    w_quo_nxt;
    logic [2*W-1:0]  w_prod;
    logic [W-1:0]    w_q;
    logic [W-1:0]    w_r;
    logic [W-1:0]    w_final;

    assign w_a_sgn  = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
    assign w_b_sgn  = (op == 3'b000) || (op == 3'b001) ||
                      (op == 3'b100) || (op == 3'b110);
    assign w_sa     = w_a_sgn & a[W-1];
    assign w_sb     = w_b_sgn & b[W-1];
    assign w_abs_a  = w_sa ? -a : a;
    assign w_abs_b  = w_sb ? -b : b;
    assign w_min    = {1'b1, {(W-1){1'b0}}};
    assign w_b_zero = (b == '0);
    // Signed DIV/REM overflow: most-negative / -1
    assign w_ovf    = op[2] && !op[0] && (a == w_min) && (b == '1);
    assign w_spec   = op[2] && (w_b_zero || w_ovf);

    always_comb begin
        w_spec_val = '0;
        if (w_b_zero)
            w_spec_val = op[1] ? a : '1;
        else
            w_spec_val = op[1] ? '0 : a;
    end

    assign w_accept = (r_state == S_IDLE) && start && !flush;
    assign w_last   = (r_state == S_CALC) && !flush &&
                      (r_spec || (r_cnt == CW'(W-1)));

    assign w_acc_nxt = r_acc + (r_b[0] ? r_a2 : '0);
    assign w_rem_sh  = {r_a2[2*W-1:W], r_a2[W-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_sub = w_rem_sh - {1'b0, r_b};
    assign w_rem_nxt = w_ge ? w_rem_sub[W-1:0] : w_rem_sh[W-1:0];
    assign w_quo_nxt = {r_a2[W-2:0], w_ge};

    assign w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    assign w_q    = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_r    = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    always_comb begin
        w_final = '0;
        if (r_spec)
            w_final = r_spec_val;
        else if (r_op[2])
            w_final = r_op[1] ? w_r : w_q;
        else if (r_op == 3'b000)
            w_final = w_prod[W-1:0];
        else
            w_final = w_prod[2*W-1:W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_CALC;
            S_CALC: begin
                if (flush)
                    w_state_nxt = S_IDLE;
                else if (w_last)
                    w_state_nxt = S_DONE;
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state == S_CALC);
        done  = (r_state == S_DONE);
        stall = w_accept || (r_state == S_CALC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_rd       <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_val <= '0;
            r_b        <= '0;
            r_a2       <= '0;
            r_acc      <= '0;
            result     <= '0;
            rd_out     <= '0;
        end else begin
            if (w_accept) begin
                r_op       <= op;
                r_rd       <= rd_in;
                r_neg_q    <= w_sa ^ w_sb;
                r_neg_r    <= w_sa;
                r_spec     <= w_spec;
                r_spec_val <= w_spec_val;
                r_b        <= w_abs_b;
                r_a2       <= {{W{1'b0}}, w_abs_a};
                r_acc      <= '0;
                r_cnt      <= '0;
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_op[2]) begin
                    r_a2 <= {w_rem_nxt, w_quo_nxt};
                end else begin
                    r_acc <= w_acc_nxt;
                    r_a2  <= r_a2 << 1;
                    r_b   <= r_b >> 1;
                end
            end
            if (w_last) begin
                result <= w_final;
                rd_out <= r_rd;
            end
        end
    end
endmodule
